spi_tx_queue: RTL and testbench
===============================

# spi_tx_queue

Upstream feeder for the 12-bit SPI transfer block (`top`: `newd`/`din` in, `dout`/`done` out). It buffers words written by the host into a small FIFO and launches them one at a time into the SPI master using the `newd`/`din` handshake. It waits for each transfer's `done` before launching the next. This removes per-word handshaking from the host and keeps the SPI link back-to-back busy.

## Interface
- `DW`, 12, data word width; matches the SPI block's `din`/`dout`.
- `DEPTH`, 8, FIFO entries; must be a power of two, at least 2.
- `clk` input 1: single clock, shared with the SPI block.
- `rst` input 1: synchronous, active-high reset.
- `wr_en` input 1: push `wr_data` on this edge.
- `wr_data` input DW: word to transmit.
- `full` output 1: FIFO holds DEPTH words.
- `empty` output 1: FIFO holds 0 words.
- `count` output $clog2(DEPTH)+1: current occupancy.
- `overflow` output 1: sticky; set on a write while full; cleared only by `rst`.
- `newd` output 1: launch request to the SPI master.
- `din` output DW: word being launched; stable from launch until `done` is seen.
- `sclk` input 1: SPI master serial clock; used to detect that the launch was accepted.
- `done` input 1: SPI block transfer-complete.
- `dout` input DW: SPI block received word.
- `busy` output 1: high from launch until the word is retired.
- `err_cnt` output 8: loopback mismatch count (see Configuration).
- `mismatch` output 1: one-cycle pulse on a loopback mismatch.

## Operation
- FIFO behaviour:
  - Write with `wr_en` when not full; the word is appended.
  - Write while full: the word is dropped, `overflow` is set, and FIFO state is unchanged.
  - Pop happens only on word retirement.
  - A simultaneous write and pop in one cycle is legal; `count` stays unchanged.
  - Pointers wrap modulo DEPTH.
- `sclk` and `done` are each registered once. Rise events are computed as current value & ~previous value.
- FSM states:
  - IDLE: if not empty → LAUNCH. Load `din` ← head, set `newd` = 1, set `busy` = 1.
  - LAUNCH: hold `newd` = 1 until an `sclk` rise is detected → WAIT_DONE, `newd` = 0.
  - WAIT_DONE: on a `done` rise → RETIRE.
  - RETIRE: pop the head, `busy` = 0 → IDLE.
- A `done` rise seen in LAUNCH is ignored.
- `din` holds its value while `busy` = 0.
- Reset, including mid-transfer:
  - Pointers and `count` go to 0; `empty` = 1, `full` = 0, `overflow` = 0.
  - FSM goes to IDLE; `newd` = 0, `busy` = 0, `din` = 0.
  - `err_cnt` = 0 and `mismatch` = 0.
  - An in-flight word is discarded.

## Timing
- All outputs are registered.
- Write at edge N into an empty, idle queue:
  - `count` = 1 and `empty` = 0 after N.
  - `newd` = 1 with `din` = word after N+1.
- `newd` falls on the edge after the registered `sclk` rise is detected, i.e. 2 `clk` edges after `sclk` rises.
- The pop occurs 1 cycle after the registered `done` rise (the RETIRE cycle).
- The next launch occurs 1 cycle later if the FIFO is not empty.
- Minimum gap between consecutive `newd` assertions: 2 cycles after the `done` rise is detected.
- `full` and `empty` reflect `count` after every edge. A write in the same cycle that `full` deasserts due to a pop is accepted.

## Configuration
- `SPI_TXQ_LOOPBACK_CHECK_EN` defined:
  - On a `done` rise, compare `dout` with the launched `din`.
  - On inequality, pulse `mismatch` for 1 cycle and increment `err_cnt`, saturating at 255.
  - Intended for the loopback SPI build, where the slave returns the master's word.
- Not defined: no compare logic is built; `err_cnt` is tied to 0 and `mismatch` to 0.

## Structure
- Package `spi_txq_pkg` holds:
  - the FSM state enum (IDLE, LAUNCH, WAIT_DONE, RETIRE);
  - the default data width constant (12);
  - the error counter width (8).
- Sub-module `spi_txq_fifo` is a synchronous circular buffer providing `count`, `full`, `empty` and `overflow`, with push and pop ports.
- The FSM, edge detectors and loopback check live in `spi_tx_queue`.

## Test plan
- **Reset:** hold `rst` for 5 cycles → `empty` = 1, `count` = 0, `newd` = 0, `busy` = 0, `din` = 0, `err_cnt` = 0.
- **Single word:** write 12'hA5C into the SPI loopback model → `newd` rises 2 cycles after the write and falls after the first `sclk` rise. `dout` = 12'hA5C at `done`, the queue empties, and `mismatch` never pulses.
- **Burst:** write 10 random words back-to-back into DEPTH = 8 → `full` after 8 writes, `overflow` = 1. Exactly the first 8 words are transmitted, in order; later writes are accepted once pops begin.
- **Push/pop same cycle:** a write in the RETIRE cycle with `count` = 3 → `count` stays 3 and the data order is preserved across pointer wrap.
- **Mid-transfer reset:** assert `rst` during WAIT_DONE with 3 words queued → `newd` = 0 and `count` = 0 next cycle; a later `done` pulse causes no pop and no `count` change.
- **Loopback check (macro on):** the model corrupts bit 0 of one word → one `mismatch` pulse and `err_cnt` = 1. With the macro off, `err_cnt` stays 0.

Source files
------------

// File: rtl/spi_txq_pkg.sv
// Shared types and constants for the SPI transmit queue: FSM state encoding,
// default data width and loopback error counter width.
package spi_txq_pkg;

  localparam int DW_DEF = 12;
  localparam int ERR_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_DONE,
    RETIRE
  } state_e;

endpackage

// File: rtl/spi_txq_fifo.sv
// Synchronous circular buffer feeding the SPI launcher; occupancy, full/empty
// flags and sticky overflow are all registered.
module spi_txq_fifo #(
  parameter  int DW    = 12,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [DW-1:0] head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          overflow_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, empty_q, overflow_q;
  logic          do_push, do_pop;

  // A write while full is dropped even if a pop lands on the same edge.
  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == '0);
      if (push_i && full_q) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o     = mem_q[rd_ptr_q];
  assign count_o    = count_q;
  assign full_o     = full_q;
  assign empty_o    = empty_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/spi_tx_queue.sv
// Queues host words and launches them one at a time into the SPI master.
// Define SPI_TXQ_LOOPBACK_CHECK_EN to build the dout-vs-din loopback checker.
module spi_tx_queue
  import spi_txq_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [DW-1:0]          wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   newd,
  output logic [DW-1:0]          din,
  input  logic                   sclk,
  input  logic                   done,
  input  logic [DW-1:0]          dout,
  output logic                   busy,
  output logic [ERR_W-1:0]       err_cnt,
  output logic                   mismatch
);

  state_e        state_q, state_d;
  logic          newd_q, newd_d, busy_q, busy_d;
  logic [DW-1:0] din_q, din_d;
  logic [DW-1:0] fifo_head;
  logic          pop;
  logic          sclk_q, sclk_prev_q, done_q, done_prev_q;
  logic          sclk_rise, done_rise;

  spi_txq_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (wr_en),
    .push_data_i(wr_data),
    .pop_i      (pop),
    .head_o     (fifo_head),
    .count_o    (count),
    .full_o     (full),
    .empty_o    (empty),
    .overflow_o (overflow)
  );

  // Rise detection runs on the registered copies, adding one cycle of latency.
  assign sclk_rise = sclk_q & ~sclk_prev_q;
  assign done_rise = done_q & ~done_prev_q;

  always_comb begin
    state_d = state_q;
    newd_d  = newd_q;
    busy_d  = busy_q;
    din_d   = din_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d = LAUNCH;
          din_d   = fifo_head;
          newd_d  = 1'b1;
          busy_d  = 1'b1;
        end
      end
      LAUNCH: begin
        if (sclk_rise) begin
          state_d = WAIT_DONE;
          newd_d  = 1'b0;
        end
      end
      WAIT_DONE: begin
        if (done_rise) state_d = RETIRE;
      end
      RETIRE: begin
        pop     = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      newd_q      <= 1'b0;
      busy_q      <= 1'b0;
      din_q       <= '0;
      sclk_q      <= 1'b0;
      sclk_prev_q <= 1'b0;
      done_q      <= 1'b0;
      done_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      newd_q      <= newd_d;
      busy_q      <= busy_d;
      din_q       <= din_d;
      sclk_q      <= sclk;
      sclk_prev_q <= sclk_q;
      done_q      <= done;
      done_prev_q <= done_q;
    end
  end

  assign newd = newd_q;
  assign busy = busy_q;
  assign din  = din_q;

`ifdef SPI_TXQ_LOOPBACK_CHECK_EN
  logic [ERR_W-1:0] err_cnt_q;
  logic             mismatch_q;
  logic             chk_fail;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == '1) ? v : v + ERR_W'(1);
  endfunction

  assign chk_fail = (state_q == WAIT_DONE) && done_rise && (dout != din_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q  <= '0;
      mismatch_q <= 1'b0;
    end else begin
      mismatch_q <= chk_fail;
      if (chk_fail) err_cnt_q <= sat_inc(err_cnt_q);
    end
  end

  assign err_cnt  = err_cnt_q;
  assign mismatch = mismatch_q;
`else
  logic unused_dout;
  assign unused_dout = ^dout;
  assign err_cnt     = '0;
  assign mismatch    = 1'b0;
`endif

endmodule

// File: tb/tb_spi_tx_queue.sv
// Directed bench for spi_tx_queue with an inline SPI loopback slave; loopback
// expectations follow SPI_TXQ_LOOPBACK_CHECK_EN.
module tb_spi_tx_queue;

  localparam int DW    = 12;
  localparam int DEPTH = 8;
`ifdef SPI_TXQ_LOOPBACK_CHECK_EN
  localparam bit LB = 1'b1;
`else
  localparam bit LB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, wr_en, sclk, done;
  logic [DW-1:0] wr_data, dout, din;
  logic          full, empty, overflow, newd, busy, mismatch;
  logic [3:0]    count;
  logic [7:0]    err_cnt;

  int n_total = 0;
  int n_pass  = 0;

  logic [DW-1:0] burst [10] = '{12'h101, 12'h2E2, 12'h3C3, 12'h4A4, 12'h555,
                                12'h6F6, 12'h707, 12'h818, 12'h929, 12'hABA};
  logic [DW-1:0] w;

  spi_tx_queue #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .newd(newd), .din(din), .sclk(sclk), .done(done), .dout(dout),
    .busy(busy), .err_cnt(err_cnt), .mismatch(mismatch)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic wr(input logic [DW-1:0] d);
    wr_en = 1'b1; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_launch();
    int n = 0;
    while (!newd && n < 40) begin tick(); n++; end
    chk("launch_seen", newd, 1);
  endtask

  // One full transfer as seen by a loopback slave; mask corrupts the echoed word.
  task automatic xfer(input logic [DW-1:0] mask, input logic do_wr,
                      input logic [DW-1:0] wd, input logic [3:0] exp_cnt,
                      output logic [DW-1:0] word);
    wait_launch();
    word = din;
    sclk = 1'b1; tick();
    chk("newd_hold", newd, 1);
    sclk = 1'b0; tick();
    chk("newd_fall", newd, 0);
    chk("busy_xfer", busy, 1);
    dout = din ^ mask; done = 1'b1; tick();
    done = 1'b0; tick();
    chk("mismatch_pulse", mismatch, (LB && mask != '0));
    if (do_wr) begin wr_en = 1'b1; wr_data = wd; end
    tick();
    wr_en = 1'b0;
    chk("mismatch_clear", mismatch, 0);
    chk("busy_retired", busy, 0);
    if (do_wr) chk("pushpop_count", count, exp_cnt);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; sclk = 1'b0; done = 1'b0; dout = '0;
    repeat (5) tick();
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_newd", newd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_din", din, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_full", full, 0);
    chk("rst_overflow", overflow, 0);
    rst = 1'b0;
    tick();

    // Single word: count after the write edge, newd one edge later.
    wr(12'hA5C);
    chk("single_count", count, 1);
    chk("single_empty", empty, 0);
    chk("single_newd_early", newd, 0);
    tick();
    chk("single_newd", newd, 1);
    chk("single_din", din, 12'hA5C);
    chk("single_busy", busy, 1);
    xfer('0, 1'b0, '0, '0, w);
    chk("single_word", w, 12'hA5C);
    chk("single_drained", count, 0);
    chk("single_empty_after", empty, 1);
    chk("single_din_held", din, 12'hA5C);

    // Burst of 10 into 8 entries: last two dropped, overflow sticks.
    for (int i = 0; i < 10; i++) begin
      wr(burst[i]);
      if (i == 7) begin
        chk("burst_full8", full, 1);
        chk("burst_count8", count, 8);
        chk("burst_no_ovf_yet", overflow, 0);
      end
    end
    chk("burst_count", count, 8);
    chk("burst_overflow", overflow, 1);
    chk("burst_full", full, 1);
    xfer('0, 1'b0, '0, '0, w);
    chk("burst_word0", w, burst[0]);
    chk("burst_notfull", full, 0);
    chk("burst_count7", count, 7);
    wr(12'hBCB);
    chk("burst_refill", count, 8);
    chk("burst_refull", full, 1);
    for (int i = 1; i < 8; i++) begin
      xfer('0, 1'b0, '0, '0, w);
      chk($sformatf("burst_word%0d", i), w, burst[i]);
    end
    xfer('0, 1'b0, '0, '0, w);
    chk("burst_late_word", w, 12'hBCB);
    chk("burst_empty", empty, 1);
    chk("burst_ovf_sticky", overflow, 1);

    // Push in the RETIRE cycle with three queued; pointers have wrapped already.
    wr(12'h111); wr(12'h222); wr(12'h333);
    chk("pp_count3", count, 3);
    xfer('0, 1'b1, 12'h444, 4'd3, w);
    chk("pp_word0", w, 12'h111);
    xfer('0, 1'b0, '0, '0, w);
    chk("pp_word1", w, 12'h222);
    xfer('0, 1'b0, '0, '0, w);
    chk("pp_word2", w, 12'h333);
    xfer('0, 1'b0, '0, '0, w);
    chk("pp_word3", w, 12'h444);
    chk("pp_empty", empty, 1);

    // Reset while waiting for done with three words queued.
    wr(12'h7A1); wr(12'h7A2); wr(12'h7A3);
    chk("mr_count3", count, 3);
    wait_launch();
    sclk = 1'b1; tick();
    sclk = 1'b0; tick();
    chk("mr_wait_newd", newd, 0);
    chk("mr_wait_busy", busy, 1);
    rst = 1'b1; tick();
    rst = 1'b0;
    chk("mr_newd", newd, 0);
    chk("mr_count", count, 0);
    chk("mr_busy", busy, 0);
    chk("mr_empty", empty, 1);
    chk("mr_din", din, 0);
    chk("mr_overflow", overflow, 0);
    dout = 12'h7A1; done = 1'b1; tick();
    done = 1'b0; tick(); tick(); tick();
    chk("mr_late_done_count", count, 0);
    chk("mr_late_done_busy", busy, 0);
    chk("mr_late_done_newd", newd, 0);

    // Corrupted echo on bit 0.
    wr(12'h3C3);
    xfer(12'h001, 1'b0, '0, '0, w);
    chk("lb_word", w, 12'h3C3);
    chk("lb_err_cnt", err_cnt, LB ? 1 : 0);
    wr(12'h5A5);
    xfer('0, 1'b0, '0, '0, w);
    chk("lb_clean_word", w, 12'h5A5);
    chk("lb_err_cnt_hold", err_cnt, LB ? 1 : 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
